frame_extrema_tracker: RTL



---
 rtl/frame_extrema_tracker.sv | 113 +++++++++++
 1 files changed

// File: rtl/frame_extrema_tracker.sv
// Framed 4-bit sample stream: tracks per-frame max, min, max-tie count and length,
// using an external magnitude comparator for the max/min updates.
module frame_extrema_tracker #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic [3:0]       cmp_a,
   output logic [3:0]       cmp_b,
   input  logic             aeqb,
   input  logic             agtb,
   input  logic             altb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_max,
   output logic [3:0]       out_min,
   output logic [3:0]       out_max_cnt,
   output logic [LEN_W-1:0] out_len
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CMP_MAX = 2'd1;
   localparam logic [1:0] CMP_MIN = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   logic [1:0]       state;
   logic [3:0]       sample_q;
   logic             last_q;
   logic [3:0]       max_q;
   logic [3:0]       min_q;
   logic [3:0]       cnt_q;
   logic [LEN_W-1:0] len_q;
   logic             first_q;
   logic [2:0]       flags;
   logic             flags_ok;

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign cmp_a       = sample_q;
   assign cmp_b       = (state == CMP_MIN) ? min_q : max_q;
   assign out_max     = max_q;
   assign out_min     = min_q;
   assign out_max_cnt = cnt_q;
   assign out_len     = len_q;

   // Malformed comparator flags leave the extrema untouched but never stall the FSM.
   assign flags    = {aeqb, agtb, altb};
   assign flags_ok = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sample_q <= '0;
         last_q   <= 1'b0;
         max_q    <= '0;
         min_q    <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
         first_q  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (first_q) begin
                     // First sample seeds both extrema directly; no compare needed.
                     max_q   <= in_data;
                     min_q   <= in_data;
                     cnt_q   <= 4'd1;
                     len_q   <= LEN_ONE;
                     first_q <= 1'b0;
                     state   <= in_last ? DONE : IDLE;
                  end else begin
                     sample_q <= in_data;
                     last_q   <= in_last;
                     if (len_q != LEN_MAX) len_q <= len_q + LEN_ONE;
                     state    <= CMP_MAX;
                  end
               end
            end
            CMP_MAX: begin
               if (flags_ok) begin
                  if (agtb) begin
                     max_q <= sample_q;
                     cnt_q <= 4'd1;
                  end else if (aeqb && cnt_q != 4'd15) begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               state <= CMP_MIN;
            end
            CMP_MIN: begin
               if (flags_ok && altb) min_q <= sample_q;
               state <= last_q ? DONE : IDLE;
            end
            default: begin
               // Result stays put until taken; the next frame restarts from its first sample.
               if (out_ready) begin
                  first_q <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
